// File: rtl/clk_div_tick_gen_pkg.sv
// Shared state encoding and ratio helper for the clock-enable divider.
// Optional build macro: CLK_DIV_TICK_COUNT_EN (adds the tick_count port).
package clk_div_tick_gen_pkg;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  // A ratio of zero is meaningless; run it as divide-by-one.
  function automatic logic [31:0] sane_ratio(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clk_div_ratio_reg.sv
// Ratio handshake: active ratio, shadow ratio and registered div_ready.
// Commit strobe moves the shadow into the active ratio at a period end.
module clk_div_ratio_reg
  import clk_div_tick_gen_pkg::*;
#(
  parameter int CNT_BITS    = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CNT_BITS-1:0] div_value,
  input  logic                div_valid,
  input  logic                direct_i,
  input  logic                commit_i,
  input  logic                pending_i,
  output logic                div_ready,
  output logic                accept_o,
  output logic [CNT_BITS-1:0] ratio_o,
  output logic [CNT_BITS-1:0] ratio_d_o
);

  logic [CNT_BITS-1:0] ratio_q, ratio_d;
  logic [CNT_BITS-1:0] shadow_q, shadow_d;
  logic [CNT_BITS-1:0] req;
  logic                ready_q, ready_d;

  assign req      = CNT_BITS'(sane_ratio(32'(div_value)));
  assign accept_o = div_valid && ready_q;
  assign ready_d  = !pending_i;

  always_comb begin
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    if (commit_i) begin
      ratio_d = shadow_q;
    end
    if (accept_o) begin
      if (direct_i) begin
        ratio_d = req;
      end else begin
        shadow_d = req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_q  <= CNT_BITS'(DEFAULT_DIV);
      shadow_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
    end
  end

  assign div_ready = ready_q;
  assign ratio_o   = ratio_q;
  assign ratio_d_o = ratio_d;

endmodule

// File: rtl/clk_div_tick_gen.sv
// Programmable clock-enable generator: 1-cycle tick every N clocks plus square wave.
// Optional build macro: CLK_DIV_TICK_COUNT_EN (adds the tick_count port).
module clk_div_tick_gen
  import clk_div_tick_gen_pkg::*;
#(
  parameter int CNT_BITS    = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] div_value,
  input  logic                div_valid,
  output logic                div_ready,
  output logic                tick,
  output logic                clk_div_out,
  output logic                active
`ifdef CLK_DIV_TICK_COUNT_EN
  ,
  output logic [CNT_BITS-1:0] tick_count
`endif
);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                div_q, div_d;
  logic [CNT_BITS-1:0] ratio, ratio_nx, nm1;
  logic [CNT_BITS:0]   half;
  logic                accept, commit, direct, wrap;

  clk_div_ratio_reg #(
    .CNT_BITS    (CNT_BITS),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ratio (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_value (div_value),
    .div_valid (div_valid),
    .direct_i  (direct),
    .commit_i  (commit),
    .pending_i (state_d == ST_PENDING),
    .div_ready (div_ready),
    .accept_o  (accept),
    .ratio_o   (ratio),
    .ratio_d_o (ratio_nx)
  );

  assign nm1  = ratio - CNT_BITS'(1);
  assign wrap = (cnt_q == nm1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    direct  = 1'b1;
    unique case (1'b1)
      state_q == ST_STOPPED: begin
        cnt_d = '0;
        if (enable) state_d = ST_RUNNING;
      end
      state_q == ST_RUNNING: begin
        if (!enable) begin
          state_d = ST_STOPPED;
          cnt_d   = '0;
        end else begin
          direct = 1'b0;
          cnt_d  = wrap ? '0 : cnt_q + CNT_BITS'(1);
          if (accept) state_d = ST_PENDING;
        end
      end
      state_q == ST_PENDING: begin
        direct = 1'b0;
        if (!enable) begin
          state_d = ST_STOPPED;
          cnt_d   = '0;
          commit  = 1'b1;
        end else if (wrap) begin
          state_d = ST_RUNNING;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d = ST_STOPPED;
        cnt_d   = '0;
      end
    endcase
  end

  // Square-wave phase follows the ratio that governs the next count value.
  assign half   = ({1'b0, ratio_nx} + (CNT_BITS+1)'(1)) >> 1;
  assign tick_d = (state_q != ST_STOPPED) && enable && wrap;
  assign div_d  = (state_d != ST_STOPPED) && ({1'b0, cnt_d} < half);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOPPED;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
    end
  end

  assign tick        = tick_q;
  assign clk_div_out = div_q;
  assign active      = (state_q != ST_STOPPED);

`ifdef CLK_DIV_TICK_COUNT_EN
  logic [CNT_BITS-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d == ST_STOPPED) begin
      tcnt_d = '0;
    end else if (tick_d) begin
      tcnt_d = tcnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign tick_count = tcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_tick_gen.sv
// Directed self-checking bench for clk_div_tick_gen.
// Builds with or without CLK_DIV_TICK_COUNT_EN.
module tb_clk_div_tick_gen;

  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] div_value;
  logic         div_valid;
  logic         div_ready;
  logic         tick;
  logic         clk_div_out;
  logic         active;
`ifdef CLK_DIV_TICK_COUNT_EN
  logic [W-1:0] tick_count;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_tick_gen #(
    .CNT_BITS    (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .div_value   (div_value),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .tick        (tick),
    .clk_div_out (clk_div_out),
    .active      (active)
`ifdef CLK_DIV_TICK_COUNT_EN
    ,
    .tick_count  (tick_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    div_value = '0;
    div_valid = 1'b0;
    #12;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_div", 32'(clk_div_out), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ready", 32'(div_ready), 32'd1);
    reset_n = 1'b1;
    enable  = 1'b1;

    // N=4 after reset: ticks on edges 4,8,12; wave 1,1,0,0
    for (int k = 0; k < 14; k++) begin
      step();
      chk("n4_tick", 32'(tick), 32'((k > 0) && (k % 4 == 0)));
      chk("n4_div", 32'(clk_div_out), 32'((k % 4) < 2));
      chk("n4_active", 32'(active), 32'd1);
    end

    // cnt is 1: request N=6, ready drops until the wrap
    div_value = 16'd6;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("ld6_ready0", 32'(div_ready), 32'd0);
    chk("ld6_tick0", 32'(tick), 32'd0);
    step();
    chk("ld6_ready1", 32'(div_ready), 32'd0);
    chk("ld6_tick1", 32'(tick), 32'd0);
    step();
    chk("ld6_wrap_tick", 32'(tick), 32'd1);
    chk("ld6_wrap_ready", 32'(div_ready), 32'd1);
    chk("ld6_wrap_div", 32'(clk_div_out), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("n6_tick", 32'(tick), 32'(j == 6));
      chk("n6_div", 32'(clk_div_out), 32'((j % 6) < 3));
    end

    // pending N=5, then stop mid-period: commit on the stop edge
    div_value = 16'd5;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("p5_ready", 32'(div_ready), 32'd0);
    chk("p5_active", 32'(active), 32'd1);
    step();
    enable = 1'b0;
    step();
    chk("stop_tick", 32'(tick), 32'd0);
    chk("stop_div", 32'(clk_div_out), 32'd0);
    chk("stop_active", 32'(active), 32'd0);
    chk("stop_ready", 32'(div_ready), 32'd1);
    step();
    chk("stop2_active", 32'(active), 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk("n5_tick", 32'(tick), 32'((k > 0) && (k % 5 == 0)));
      chk("n5_div", 32'(clk_div_out), 32'((k % 5) < 3));
    end

    // div_value 0 loaded while stopped behaves as N=1
    enable = 1'b0;
    step();
    chk("s0_active", 32'(active), 32'd0);
    div_value = 16'd0;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("s0_ready", 32'(div_ready), 32'd1);
    enable = 1'b1;
    step();
    chk("n1_first_tick", 32'(tick), 32'd0);
    chk("n1_first_div", 32'(clk_div_out), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("n1_tick", 32'(tick), 32'd1);
      chk("n1_div", 32'(clk_div_out), 32'd1);
    end

    // asynchronous reset in the middle of a clock period
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_div", 32'(clk_div_out), 32'd0);
    chk("arst_active", 32'(active), 32'd0);
    chk("arst_ready", 32'(div_ready), 32'd1);
`ifdef CLK_DIV_TICK_COUNT_EN
    chk("arst_tcnt", 32'(tick_count), 32'd0);
`endif
    reset_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk("post_tick", 32'(tick), 32'((k > 0) && (k % 4 == 0)));
`ifdef CLK_DIV_TICK_COUNT_EN
      chk("post_tcnt", 32'(tick_count), 32'(k / 4));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
